gpio_burst_ctrl: RTL and testbench

Half-duplex burst sequencer for the 8-bit host GPIO bus (RP_CS / RP_data) of the HSM interface. It captures a fixed-size command burst from the host and streams it to the HSM core. It then collects a response burst of the same size from the core, performs a bus turnaround and drives the response back to the host. It sits between the bidirectional pad logic in the top level and the HSM core, and owns the bus direction (`RP_oe`).

---
 rtl/gpio_burst_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_gpio_burst_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_burst_ctrl.sv
// Half-duplex burst sequencer for the host GPIO bus: receives a command burst,
// collects an equal-sized response from the core and drives it back after a bus turnaround.
module gpio_burst_ctrl #(
    parameter int BURST_SIZE  = 8,
    parameter int DATA_W      = 8,
    parameter int TURNAROUND  = 2,
    parameter int RSP_TIMEOUT = 1024
) (
    input  logic              CLK_50,
    input  logic              rst,
    input  logic              RP_CS,
    input  logic [DATA_W-1:0] RP_din,
    output logic [DATA_W-1:0] RP_dout,
    output logic              RP_oe,
    output logic              RP_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_last,
    output logic              rx_abort,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rsp_timeout,
    output logic              busy
);

    localparam int CW = $clog2(BURST_SIZE + 1);
    localparam int IW = $clog2(BURST_SIZE);
    localparam int TW = $clog2(RSP_TIMEOUT + 1);
    localparam int NW = $clog2(TURNAROUND + 1);

    localparam logic [CW-1:0] LAST_IDX  = CW'(BURST_SIZE - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(BURST_SIZE);
    localparam logic [TW-1:0] TMO_LAST  = TW'(RSP_TIMEOUT - 1);
    localparam logic [NW-1:0] TURN_LAST = NW'(TURNAROUND - 1);
    localparam logic [IW-1:0] IDX0      = '0;

    typedef enum logic [2:0] {IDLE, RX, WAIT_RSP, TURN, TX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [NW-1:0]     turn_q, turn_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_last_q, rx_last_d;
    logic              rx_abort_q, rx_abort_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              oe_q, oe_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rsp_buf_q [BURST_SIZE];
    logic [DATA_W-1:0] rsp_buf_d [BURST_SIZE];

    logic [CW-1:0] cnt_inc;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          buf_full, buf_wr, full_next;

    assign cnt_inc   = cnt_q + CW'(1);
    assign wr_idx    = cnt_q[IW-1:0];
    assign rd_idx    = cnt_inc[IW-1:0];
    assign buf_full  = (cnt_q == FULL_CNT);
    assign tx_ready  = (state_q == WAIT_RSP) && !buf_full;
    assign buf_wr    = tx_ready && tx_valid;
    // A byte landing in the timeout cycle itself still completes the response in time.
    assign full_next = buf_full || (buf_wr && (cnt_inc == FULL_CNT));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmo_d         = '0;
        turn_d        = '0;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_last_d     = 1'b0;
        rx_abort_d    = 1'b0;
        rsp_timeout_d = 1'b0;
        oe_d          = 1'b0;
        ack_d         = 1'b0;
        dout_d        = '0;
        rsp_buf_d     = rsp_buf_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (RP_CS) begin
                    rx_data_d  = RP_din;
                    rx_valid_d = 1'b1;
                    cnt_d      = CW'(1);
                    state_d    = RX;
                end
            end
            RX: begin
                if (RP_CS) begin
                    rx_data_d  = RP_din;
                    rx_valid_d = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        rx_last_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = WAIT_RSP;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    rx_abort_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end
            end
            WAIT_RSP: begin
                if (buf_wr) begin
                    rsp_buf_d[wr_idx] = tx_data;
                    cnt_d             = cnt_inc;
                end
                if (!buf_full) begin
                    tmo_d = tmo_q + TW'(1);
                end else begin
                    tmo_d = tmo_q;
                end
                if (buf_full && !RP_CS) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = TURN;
                end else if (!full_next && (tmo_q == TMO_LAST)) begin
                    rsp_timeout_d = 1'b1;
                    cnt_d         = '0;
                    tmo_d         = '0;
                    state_d       = IDLE;
                end
            end
            TURN: begin
                if (RP_CS) begin
                    turn_d = '0;
                end else if (turn_q == TURN_LAST) begin
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    ack_d   = 1'b1;
                    dout_d  = rsp_buf_q[IDX0];
                    state_d = TX;
                end else begin
                    turn_d = turn_q + NW'(1);
                end
            end
            TX: begin
                // Host reclaiming the bus aborts the response; that CS edge is not a command byte.
                if (RP_CS || (cnt_q == LAST_IDX)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_inc;
                    oe_d   = 1'b1;
                    ack_d  = 1'b1;
                    dout_d = rsp_buf_q[rd_idx];
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_50 or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tmo_q         <= '0;
            turn_q        <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_last_q     <= 1'b0;
            rx_abort_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            oe_q          <= 1'b0;
            ack_q         <= 1'b0;
            dout_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            turn_q        <= turn_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_last_q     <= rx_last_d;
            rx_abort_q    <= rx_abort_d;
            rsp_timeout_q <= rsp_timeout_d;
            oe_q          <= oe_d;
            ack_q         <= ack_d;
            dout_q        <= dout_d;
        end
    end

    always_ff @(posedge CLK_50) begin
        rsp_buf_q <= rsp_buf_d;
    end

    // Never drive the pad while the host holds CS, even within a registered TX cycle.
    assign RP_oe       = oe_q & ~RP_CS;
    assign RP_dout     = dout_q;
    assign RP_ack      = ack_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_last     = rx_last_q;
    assign rx_abort    = rx_abort_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_burst_ctrl.sv
// Self-checking bench for gpio_burst_ctrl: vector table for command bursts plus
// scoreboard queues for received command bytes and transmitted response bytes.
module tb_gpio_burst_ctrl;

    logic       CLK_50 = 1'b0;
    logic       rst;
    logic       RP_CS;
    logic [7:0] RP_din;
    logic [7:0] RP_dout;
    logic       RP_oe;
    logic       RP_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_last;
    logic       rx_abort;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rsp_timeout;
    logic       busy;

    gpio_burst_ctrl #(
        .BURST_SIZE (8),
        .DATA_W     (8),
        .TURNAROUND (2),
        .RSP_TIMEOUT(1024)
    ) dut (
        .CLK_50     (CLK_50),
        .rst        (rst),
        .RP_CS      (RP_CS),
        .RP_din     (RP_din),
        .RP_dout    (RP_dout),
        .RP_oe      (RP_oe),
        .RP_ack     (RP_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_last    (rx_last),
        .rx_abort   (rx_abort),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rsp_timeout(rsp_timeout),
        .busy       (busy)
    );

    always #5 CLK_50 = ~CLK_50;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } rx_exp_t;

    typedef struct {
        logic       cs;
        logic [7:0] din;
        logic       cap;
        logic       last;
        logic       abort;
        logic       busy;
    } vec_t;

    rx_exp_t    rxq[$];
    logic [7:0] txq[$];
    int         checks = 0;
    int         passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK_50);
        @(negedge CLK_50);
    endtask

    task automatic applyStimulus(input logic cs, input logic [7:0] din,
                                 input logic tv, input logic [7:0] td);
        RP_CS    = cs;
        RP_din   = din;
        tx_valid = tv;
        tx_data  = td;
        tick();
    endtask

    task automatic sendBurst(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            rxq.push_back({8'(base + 8'(i)), (i == 7)});
            applyStimulus(1'b1, 8'(base + 8'(i)), 1'b0, 8'h00);
        end
    endtask

    task automatic fillResponse(input logic [7:0] base, input logic cs);
        for (int i = 0; i < 8; i++) begin
            txq.push_back(8'(base + 8'(i)));
            applyStimulus(cs, 8'h00, 1'b1, 8'(base + 8'(i)));
        end
        applyStimulus(cs, 8'h00, 1'b0, 8'h00);
    endtask

    // Scoreboard: every registered output byte is matched against the oldest expectation.
    always @(negedge CLK_50) begin
        rx_exp_t    e;
        logic [7:0] t;
        if (!rst) begin
            if (rx_valid) begin
                if (rxq.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL rx_unexpected: got byte %0h, want no rx_valid", rx_data);
                end else begin
                    e = rxq.pop_front();
                    checkOutput("rx_data", 32'(rx_data), 32'(e.data));
                    checkOutput("rx_last", 32'(rx_last), 32'(e.last));
                end
            end
            if (RP_ack) begin
                if (txq.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL tx_unexpected: got byte %0h, want no RP_ack", RP_dout);
                end else begin
                    t = txq.pop_front();
                    checkOutput("tx_dout", 32'(RP_dout), 32'(t));
                end
            end
        end
    end

    initial begin
        vec_t vecs[15];
        int   sent;
        int   wait_cyc;
        logic oe_seen;

        // Truncated 5-byte command, then a full nominal command 0x88..0xFF.
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 8'(8'hA0 + 8'(i)), 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) vecs[7+i] = '{1'b1, 8'(8'h88 + 8'(8'h11 * i)), 1'b1, (i == 7), 1'b0, 1'b1};

        rst      = 1'b1;
        RP_CS    = 1'b0;
        RP_din   = 8'h00;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #2;
        checkOutput("rst_dout", 32'(RP_dout), 0);
        checkOutput("rst_oe", 32'(RP_oe), 0);
        checkOutput("rst_ack", 32'(RP_ack), 0);
        checkOutput("rst_rx_data", 32'(rx_data), 0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 0);
        checkOutput("rst_rx_last", 32'(rx_last), 0);
        checkOutput("rst_rx_abort", 32'(rx_abort), 0);
        checkOutput("rst_tx_ready", 32'(tx_ready), 0);
        checkOutput("rst_timeout", 32'(rsp_timeout), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        @(negedge CLK_50);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].cap) rxq.push_back({vecs[i].din, vecs[i].last});
            applyStimulus(vecs[i].cs, vecs[i].din, 1'b0, 8'h00);
            checkOutput($sformatf("vec%0d_abort", i), 32'(rx_abort), 32'(vecs[i].abort));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
        end

        // Nominal response with gaps while CS stays high, then turnaround and TX.
        sent = 0;
        for (int c = 0; c < 20 && sent < 8; c++) begin
            checkOutput("tx_ready_open", 32'(tx_ready), 1);
            checkOutput("oe_wait", 32'(RP_oe), 0);
            if (c % 2 == 1) begin
                txq.push_back(8'(8'h11 * (sent + 1)));
                applyStimulus(1'b1, 8'h5A, 1'b1, 8'(8'h11 * (sent + 1)));
                sent++;
            end else begin
                applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
            end
        end
        checkOutput("tx_ready_full", 32'(tx_ready), 0);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
            checkOutput($sformatf("turn_oe_%0d", c), 32'(RP_oe), 32'(c == 3));
            checkOutput($sformatf("turn_ack_%0d", c), 32'(RP_ack), 32'(c == 3));
        end
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
            checkOutput($sformatf("tx_oe_%0d", i), 32'(RP_oe), 1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("tx_done_busy", 32'(busy), 0);
        checkOutput("tx_done_oe", 32'(RP_oe), 0);
        checkOutput("txq_drained", 32'(txq.size()), 0);

        // Response timeout: only 3 bytes supplied.
        sendBurst(8'h30);
        wait_cyc = 0;
        oe_seen  = 1'b0;
        while (!rsp_timeout && wait_cyc < 1100) begin
            applyStimulus(1'b0, 8'h00, (wait_cyc < 3), 8'(8'hE0 + 8'(wait_cyc)));
            wait_cyc++;
            oe_seen = oe_seen | RP_oe | RP_ack;
        end
        checkOutput("timeout_cycle", 32'(wait_cyc), 1024);
        checkOutput("timeout_busy", 32'(busy), 0);
        checkOutput("timeout_ready", 32'(tx_ready), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("timeout_pulse", 32'(rsp_timeout), 0);
        checkOutput("timeout_no_oe", 32'(oe_seen), 0);

        // Contention: CS high after fill, CS pulse in TURN, CS pulse at TX byte 3.
        sendBurst(8'h40);
        fillResponse(8'h51, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
            checkOutput("hold_busy", 32'(busy), 1);
            checkOutput("hold_ready", 32'(tx_ready), 0);
            checkOutput("hold_oe", 32'(RP_oe), 0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("turn1_oe", 32'(RP_oe), 0);
        applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
        checkOutput("turn_cs_oe", 32'(RP_oe), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("turn_restart_oe", 32'(RP_oe), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("turn_end_oe", 32'(RP_oe), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        RP_CS = 1'b1;
        #1;
        checkOutput("oe_gated", 32'(RP_oe), 0);
        applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
        checkOutput("txabort_busy", 32'(busy), 0);
        checkOutput("txabort_ack", 32'(RP_ack), 0);
        checkOutput("txabort_oe", 32'(RP_oe), 0);
        checkOutput("txabort_left", 32'(txq.size()), 4);
        txq.delete();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("txabort_idle", 32'(busy), 0);

        // Asynchronous reset in the middle of TX.
        sendBurst(8'h60);
        fillResponse(8'h71, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("pre_rst_oe", 32'(RP_oe), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_oe", 32'(RP_oe), 0);
        checkOutput("arst_ack", 32'(RP_ack), 0);
        checkOutput("arst_busy", 32'(busy), 0);
        checkOutput("arst_dout", 32'(RP_dout), 0);
        checkOutput("arst_rx_valid", 32'(rx_valid), 0);
        checkOutput("arst_tx_ready", 32'(tx_ready), 0);
        txq.delete();
        @(negedge CLK_50);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("post_rst_busy", 32'(busy), 0);
        checkOutput("rxq_drained", 32'(rxq.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
